// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcode and FSM state encodings.
package alu_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the ALU arbiter.
// Optional rsp_zero/rsp_carry exist only with ALU_ARBITER_FLAGS_EN defined.
interface alu_arbiter_if #(parameter int WIDTH = 16);
  import alu_pkg::*;

  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  op_e              req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_ARBITER_FLAGS_EN
  logic             rsp_zero, rsp_carry;
`endif

  // Arbiter side
  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
`ifdef ALU_ARBITER_FLAGS_EN
          , rsp_zero, rsp_carry
`endif
  );

  // Requesters/consumer side
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
`ifdef ALU_ARBITER_FLAGS_EN
          , rsp_zero, rsp_carry
`endif
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: AND/OR/XOR/ADD, ADD carry-out, else carry 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  // Select the operation; the add is one bit wider to expose the carry
  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADD:  {carry, y} = {1'b0, a} + {1'b0, b};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU.
// IDLE grants and latches, EXEC registers the result, RESP holds it
// until the consumer takes it. Optional flags: ALU_ARBITER_FLAGS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic [NUM_REQ-1:0] vld;
  logic             gnt_id;
  logic             last_q;     // requester served last; 1 after reset so 0 wins first
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             rdy0, rdy1;
`ifdef ALU_ARBITER_FLAGS_EN
  logic             zero_q, carry_q;
`endif

  assign vld = {bus.req1_valid, bus.req0_valid};

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .y     (y),
    .carry (carry)
  );

  // Round-robin pick: contested -> the one not served last; otherwise the lone valid
  always_comb begin
    gnt_id = (&vld) ? ~last_q : vld[1];
  end

  // Next state and combinational accept strobes
  always_comb begin
    state_d = state_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    case (state_q)
      ST_IDLE: if (rst_n && (|vld)) begin
        rdy0    = ~gnt_id;
        rdy1    = gnt_id;
        state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture on grant, result capture in EXEC, pointer update on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
`ifdef ALU_ARBITER_FLAGS_EN
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
`endif
    end else begin
      if (state_q == ST_IDLE && (|vld)) begin
        id_q <= gnt_id;
        op_q <= gnt_id ? bus.req1_op : bus.req0_op;
        a_q  <= gnt_id ? bus.req1_a  : bus.req0_a;
        b_q  <= gnt_id ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= y;
`ifdef ALU_ARBITER_FLAGS_EN
        zero_q     <= (y == '0);
        carry_q    <= carry;
`endif
      end
      if (state_q == ST_RESP && bus.rsp_ready) last_q <= id_q;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = rsp_data_q;
`ifdef ALU_ARBITER_FLAGS_EN
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_carry  = carry_q;
`else
  // carry only feeds the optional flag register
  logic unused_carry;
  assign unused_carry = carry;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then random
// traffic, each cycle compared against a transaction-level model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: at most one operation in flight, described by its age in cycles
  bit          m_busy;
  int          m_age;
  bit          m_id;
  bit          m_last;
  int unsigned m_res;
  bit          m_carry;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned alu_ref(input op_e op, input int unsigned a, input int unsigned b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return (a + b) % 65536;
    endcase
  endfunction

  // One clock cycle: drive, check at negedge, advance model at posedge
  task automatic step(input bit rst, input bit rr,
                      input bit v0, input op_e o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input bit v1, input op_e o1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    bit e0, e1, g;
    rst_n = rst;
    bus.rsp_ready = rr;
    bus.req0_valid = v0; bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1;
    e0 = 1'b0; e1 = 1'b0;
    if (rst && !m_busy && (v0 || v1)) begin
      g  = (v0 && v1) ? !m_last : v1;
      e0 = !g;
      e1 = g;
    end
    @(negedge clk);
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    chk("rsp_valid", bus.rsp_valid, m_busy && m_age >= 2);
    if (m_busy && m_age >= 2) begin
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_data", bus.rsp_data, m_res);
`ifdef ALU_ARBITER_FLAGS_EN
      chk("rsp_zero", bus.rsp_zero, m_res == 0);
      chk("rsp_carry", bus.rsp_carry, m_carry);
`endif
    end
    @(posedge clk);
    if (!rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (!m_busy) begin
      if (v0 || v1) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_id    = e1;
        m_res   = e1 ? alu_ref(o1, a1, b1) : alu_ref(o0, a0, b0);
        m_carry = e1 ? (o1 == OP_ADD && (int'(a1) + int'(b1)) > 65535)
                     : (o0 == OP_ADD && (int'(a0) + int'(b0)) > 65535);
      end
    end else if (m_age >= 2 && rr) begin
      m_busy = 1'b0;
      m_last = m_id;
    end else begin
      m_age++;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(1, rr, 0, OP_AND, 0, 0, 0, OP_AND, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, OP_AND, 0, 0, 0, OP_AND, 0, 0);
    step(0, 0, 1, OP_ADD, 16'h1, 16'h1, 1, OP_ADD, 16'h1, 16'h1);
  endtask

  initial begin
    m_busy = 0; m_age = 0; m_id = 0; m_last = 1; m_res = 0; m_carry = 0;
    bus.rsp_ready = 0;
    bus.req0_valid = 0; bus.req0_op = OP_AND; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = OP_AND; bus.req1_a = 0; bus.req1_b = 0;
    #1;
    do_reset();
    chk("reset_data", bus.rsp_data, 0);
    chk("reset_id", bus.rsp_id, 0);
`ifdef ALU_ARBITER_FLAGS_EN
    chk("reset_zero", bus.rsp_zero, 0);
    chk("reset_carry", bus.rsp_carry, 0);
`endif

    // Single requester 0: AND FFFF & AAAA
    step(1, 1, 1, OP_AND, 16'hFFFF, 16'hAAAA, 0, OP_AND, 0, 0);
    idle(3, 1);

    // Contention from reset: 0, 1, then 0 again
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1, 1, 1, OP_XOR, 16'h5555, 16'hAAAA, 1, OP_OR, 16'h0F0F, 16'hF000);
    idle(3, 1);

    // Wrap-around add from requester 1
    step(1, 1, 0, OP_AND, 0, 0, 1, OP_ADD, 16'hFFFF, 16'h0001);
    idle(3, 1);

    // Consumer stalls 5 cycles in RESP while req1 waits
    step(1, 0, 1, OP_OR, 16'h1234, 16'h4321, 0, OP_AND, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, OP_AND, 0, 0, 1, OP_XOR, 16'hFF00, 16'h0FF0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, OP_AND, 0, 0, 1, OP_XOR, 16'hFF00, 16'h0FF0);
    idle(3, 1);

    // Reset during EXEC aborts the operation
    step(1, 1, 1, OP_ADD, 16'h7777, 16'h1111, 0, OP_AND, 0, 0);
    step(0, 1, 0, OP_AND, 0, 0, 0, OP_AND, 0, 0);
    idle(4, 1);

    // Random traffic, including occasional resets
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 6), op_e'($urandom_range(0, 3)),
           W'($urandom), W'($urandom),
           ($urandom_range(0, 9) < 6), op_e'($urandom_range(0, 3)),
           W'($urandom), W'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
